// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared constants, op encoding and sizing helper for the
//               pipelined carry-lookahead adder.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int cla_groups(input int width);
        return width / CLA_GROUP_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla4_group.sv
`default_nettype none
// ============================================================================
// Module      : cla4_group
// Description : Combinational 4-bit carry-lookahead group with group P/G.
// Revision    : 1.0 - initial release
// ============================================================================
module cla4_group
    import cla_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] i_a,
    input  logic [CLA_GROUP_W-1:0] i_b,
    input  logic                   i_cin,
    output logic [CLA_GROUP_W-1:0] o_sum,
    output logic                   o_cout,
    output logic                   o_p,
    output logic                   o_g
);

    logic [CLA_GROUP_W-1:0] w_p;
    logic [CLA_GROUP_W-1:0] w_g;
    logic [CLA_GROUP_W-1:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_p    = &w_p;
    assign o_g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_cout = o_g | (o_p & i_cin);
    assign o_sum  = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_adder
// Description : Skewed pipelined CLA add/sub with valid/ready flow control.
//               Define CLA_PIPE_SAT_EN to clamp signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_sat
);

    localparam int c_ng  = cla_groups(WIDTH);
    localparam int c_gps = c_ng / STAGES;
    localparam int c_sw  = c_gps * CLA_GROUP_W;

    // Stage k inputs: operands are right-aligned so slice k is always at bit 0
    logic [WIDTH-1:0] w_a_q [STAGES];
    logic [WIDTH-1:0] w_b_q [STAGES];
    logic [WIDTH-1:0] w_s_q [STAGES];
    logic             w_c_q [STAGES];
    logic             w_v_q [STAGES];
    logic             w_en;
    op_e              w_op;

    assign w_op     = in_sub ? OP_SUB : OP_ADD;
    assign w_en     = ~out_valid | out_ready;
    assign in_ready = rst | w_en;

    assign w_a_q[0] = in_a;
    assign w_b_q[0] = (w_op == OP_SUB) ? ~in_b : in_b;
    assign w_c_q[0] = (w_op == OP_SUB) ? 1'b1 : in_cin;
    assign w_s_q[0] = '0;
    assign w_v_q[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [c_sw-1:0]  w_sa;
        logic [c_sw-1:0]  w_sb;
        logic [c_sw-1:0]  w_ss;
        logic [c_gps:0]   w_gc;
        logic [c_gps-1:0] w_gp;
        logic [c_gps-1:0] w_gg;
        logic [c_gps-1:0] w_gco;
        logic [WIDTH-1:0] w_s_nx;
        logic             w_unused_co;

        assign w_sa    = w_a_q[k][c_sw-1:0];
        assign w_sb    = w_b_q[k][c_sw-1:0];
        assign w_gc[0] = w_c_q[k];

        for (genvar j = 0; j < c_gps; j++) begin : g_grp
            cla4_group u_grp (
                .i_a   (w_sa[j*CLA_GROUP_W +: CLA_GROUP_W]),
                .i_b   (w_sb[j*CLA_GROUP_W +: CLA_GROUP_W]),
                .i_cin (w_gc[j]),
                .o_sum (w_ss[j*CLA_GROUP_W +: CLA_GROUP_W]),
                .o_cout(w_gco[j]),
                .o_p   (w_gp[j]),
                .o_g   (w_gg[j])
            );
            assign w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
        end

        // Group couts equal the inter-group lookahead carries; only P/G are used
        assign w_unused_co = ^w_gco;

        // Finished slices enter at the top and shift down one slice per stage
        if (c_sw < WIDTH) begin : g_shift
            assign w_s_nx = {w_ss, w_s_q[k][WIDTH-1:c_sw]};
        end else begin : g_full
            assign w_s_nx = w_ss;
        end

        if (k < STAGES - 1) begin : g_mid
            logic             r_v;
            logic             r_c;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_s;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                    r_s <= '0;
                end else if (w_en) begin
                    r_v <= w_v_q[k];
                    r_c <= w_gc[c_gps];
                    r_a <= w_a_q[k] >> c_sw;
                    r_b <= w_b_q[k] >> c_sw;
                    r_s <= w_s_nx;
                end
            end

            assign w_v_q[k+1] = r_v;
            assign w_c_q[k+1] = r_c;
            assign w_a_q[k+1] = r_a;
            assign w_b_q[k+1] = r_b;
            assign w_s_q[k+1] = r_s;
        end else begin : g_last
            logic             w_cmsb;
            logic             w_ovf;
            logic             w_sat;
            logic [WIDTH-1:0] w_res;
            logic             r_v;
            logic             r_co;
            logic             r_ovf;
            logic             r_sat;
            logic [WIDTH-1:0] r_s;

            // Carry into the MSB recovered from its sum bit
            assign w_cmsb = w_sa[c_sw-1] ^ w_sb[c_sw-1] ^ w_ss[c_sw-1];
            assign w_ovf  = w_cmsb ^ w_gc[c_gps];

`ifdef CLA_PIPE_SAT_EN
            logic [WIDTH-1:0] w_lim;
            assign w_lim = w_sa[c_sw-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
            assign w_res = w_ovf ? w_lim : w_s_nx;
            assign w_sat = w_ovf;
`else
            assign w_res = w_s_nx;
            assign w_sat = 1'b0;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v   <= 1'b0;
                    r_co  <= 1'b0;
                    r_ovf <= 1'b0;
                    r_sat <= 1'b0;
                    r_s   <= '0;
                end else if (w_en) begin
                    r_v   <= w_v_q[k];
                    r_co  <= w_gc[c_gps];
                    r_ovf <= w_ovf;
                    r_sat <= w_sat;
                    r_s   <= w_res;
                end
            end

            assign out_valid = r_v;
            assign out_sum   = r_s;
            assign out_cout  = r_co;
            assign out_ovf   = r_ovf;
            assign out_sat   = r_sat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_adder
// Description : Scoreboard bench for cla_pipe_adder (WIDTH=16, STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 2;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             sat;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_sat;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic lat_chk = 1'b1;
    exp_t q[$];

    logic             held = 1'b0;
    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout, prev_ovf, prev_sat;

    cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t             e;
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   r;
        be    = sub ? ~b : b;
        r     = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = r[WIDTH-1:0];
        e.cout = r[WIDTH];
        e.ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        e.sat  = 1'b0;
`ifdef CLA_PIPE_SAT_EN
        if (e.ovf) begin
            e.sum = a[WIDTH-1] ? 16'h8000 : 16'h7FFF;
            e.sat = 1'b1;
        end
`endif
        e.cyc = 0;
        return e;
    endfunction

    // Transfers are judged at the falling edge, ahead of the rising edge that commits them
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (held) begin
                chk("hold_sum",  {16'b0, out_sum},   {16'b0, prev_sum});
                chk("hold_flag", {29'b0, out_cout, out_ovf, out_sat},
                                 {29'b0, prev_cout, prev_ovf, prev_sat});
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", {31'b0, out_valid}, 32'd0);
                end else if (out_ready) begin
                    e = q.pop_front();
                    chk("sum",  {16'b0, out_sum}, {16'b0, e.sum});
                    chk("cout", {31'b0, out_cout}, {31'b0, e.cout});
                    chk("ovf",  {31'b0, out_ovf},  {31'b0, e.ovf});
                    chk("sat",  {31'b0, out_sat},  {31'b0, e.sat});
                    if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'(STAGES));
                end
            end
            held      = out_valid && !out_ready;
            prev_sum  = out_sum;
            prev_cout = out_cout;
            prev_ovf  = out_ovf;
            prev_sat  = out_sat;
            if (in_valid && in_ready) begin
                e     = model(in_a, in_b, in_cin, in_sub);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        int   n = 0;
        logic acc;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_sum"},   {16'b0, out_sum},   32'd0);
        chk({tag, "_flags"}, {29'b0, out_cout, out_ovf, out_sat}, 32'd0);
        chk({tag, "_ready"}, {31'b0, in_ready},  32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corners, one beat at a time
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
        send(16'h00FF, 16'h0001, 1'b0, 1'b0); drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();
        send(16'h0005, 16'h0007, 1'b0, 1'b1); drain();
        send(16'h0005, 16'h0007, 1'b1, 1'b1); drain();
        send(16'h8000, 16'h0001, 1'b0, 1'b1); drain();
        send(16'h1234, 16'h4321, 1'b1, 1'b0); drain();
        send(16'h8000, 16'h8000, 1'b0, 1'b0); drain();

        // Back-to-back stream with no stall
        for (int i = 0; i < 6; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();

        // Stream of 8 with a 3-cycle output stall early on
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Reset with two beats in flight
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("midreset");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("leftover", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
